// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies, FSM state type and small op-classification helpers.
package md_unit_pkg;

    localparam logic [2:0] MDOP_NONE  = 3'b000;
    localparam logic [2:0] MDOP_MULT  = 3'b001;
    localparam logic [2:0] MDOP_MULTU = 3'b010;
    localparam logic [2:0] MDOP_DIV   = 3'b011;
    localparam logic [2:0] MDOP_DIVU  = 3'b100;
    localparam logic [2:0] MDOP_MTHI  = 3'b101;
    localparam logic [2:0] MDOP_MTLO  = 3'b110;
    localparam logic [2:0] MDOP_NONE7 = 3'b111;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

    // True for the four ops that occupy the unit for multiple cycles.
    function automatic logic is_calc_op(input logic [2:0] op);
        return (op == MDOP_MULT) || (op == MDOP_MULTU) ||
               (op == MDOP_DIV)  || (op == MDOP_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MDOP_DIV) || (op == MDOP_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// Operand/result bundle between the execute stage and the multiply/divide unit.
interface md_unit_if;

    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  MDOp;
    logic        RdSel;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] Out;

    modport master (
        output A, B, MDOp, RdSel,
        input  Busy, HI, LO, Out
    );

    modport slave (
        input  A, B, MDOp, RdSel,
        output Busy, HI, LO, Out
    );

endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | unit free; mult/div start accepted, mthi/mtlo serviced
//   ST_RUN  | calculation in flight; counter runs down, commit at zero
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic      clk,
    input  logic      reset,
    md_unit_if.slave  md
);

    localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = ($clog2(MAX_LAT) < 1) ? 1 : $clog2(MAX_LAT);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       op_q;
    logic [31:0]      a_q, b_q;
    logic [31:0]      hi_q, lo_q;
    logic             start, commit;

    logic [63:0]      prod;
    logic [31:0]      b_nz, a_mag, b_mag, dvd, dvs, quo, rem;
    logic             div_signed;
    logic [31:0]      res_hi, res_lo;
    logic             res_we;

    // State register for the start/run/commit sequencer.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state plus start/commit strobes; starts are only seen in idle,
    // so an op arriving while busy is dropped rather than queued.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_calc_op(md.MDOp)) begin
                    start   = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Result datapath on the latched operands. One unsigned divider serves
    // both div and divu; signed div works on magnitudes and fixes signs after,
    // which also yields 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
    always_comb begin
        prod       = (op_q == MDOP_MULT)
                   ? ({{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q})
                   : ({32'b0, a_q} * {32'b0, b_q});
        b_nz       = (b_q == 32'd0) ? 32'd1 : b_q;
        div_signed = (op_q == MDOP_DIV);
        a_mag      = a_q[31]  ? (32'd0 - a_q)  : a_q;
        b_mag      = b_nz[31] ? (32'd0 - b_nz) : b_nz;
        dvd        = div_signed ? a_mag : a_q;
        dvs        = div_signed ? b_mag : b_nz;
        quo        = dvd / dvs;
        rem        = dvd % dvs;
        if (div_signed && (a_q[31] ^ b_nz[31])) quo = 32'd0 - quo;
        if (div_signed && a_q[31])               rem = 32'd0 - rem;

        res_hi = 32'd0;
        res_lo = 32'd0;
        res_we = 1'b0;
        case (op_q)
            MDOP_MULT, MDOP_MULTU: begin
                res_hi = prod[63:32];
                res_lo = prod[31:0];
                res_we = 1'b1;
            end
            MDOP_DIV, MDOP_DIVU: begin
                res_hi = rem;
                res_lo = quo;
                res_we = (b_q != 32'd0);
            end
            default: ;
        endcase
    end

    // Operand latch, latency down-counter and HI/LO write ports.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            op_q  <= MDOP_NONE;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
        end else begin
            if (start) begin
                op_q  <= md.MDOp;
                a_q   <= md.A;
                b_q   <= md.B;
                cnt_q <= is_div_op(md.MDOp) ? DIV_LOAD : MULT_LOAD;
            end else if (state_q == ST_RUN && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end

            if (commit && res_we) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else if (state_q == ST_IDLE) begin
                if (md.MDOp == MDOP_MTHI) hi_q <= md.A;
                if (md.MDOp == MDOP_MTLO) lo_q <= md.A;
            end
        end
    end

    assign md.Busy = (state_q == ST_RUN);
    assign md.HI   = hi_q;
    assign md.LO   = lo_q;
    assign md.Out  = md.RdSel ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: vector table for mult/div results and
// latency, hand sequences for mthi/mtlo, busy-time ignores and reset.
module tb_md_unit;
    import md_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;

    md_unit_if mdi ();

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (mdi)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    // Drive one op at a negedge, then count busy cycles (bounded).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int ncyc);
        @(negedge clk);
        mdi.MDOp = op;
        mdi.A    = a;
        mdi.B    = b;
        @(posedge clk);
        #1;
        mdi.MDOp = MDOP_NONE;
        mdi.A    = 32'h5A5A_5A5A;
        mdi.B    = 32'hA5A5_A5A5;
        ncyc = 0;
        while (mdi.Busy && ncyc < 100) begin
            @(posedge clk);
            #1;
            ncyc++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        vecs[0] = '{MDOP_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vecs[1] = '{MDOP_MULTU, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA, 5};
        vecs[2] = '{MDOP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3] = '{MDOP_DIVU,  32'd7,         32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[4] = '{MDOP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
        vecs[5] = '{MDOP_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 10};
        vecs[6] = '{MDOP_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 5};
        vecs[7] = '{MDOP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
        vecs[8] = '{MDOP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
        vecs[9] = '{MDOP_DIV,   32'd5,         32'd0,         32'hFFFF_FFFE, 32'h0000_0001, 10};

        reset     = 1'b1;
        mdi.A     = 32'd0;
        mdi.B     = 32'd0;
        mdi.MDOp  = MDOP_NONE;
        mdi.RdSel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hi",   mdi.HI,   32'd0);
        check("reset_lo",   mdi.LO,   32'd0);
        check("reset_busy", {31'd0, mdi.Busy}, 32'd0);
        check("reset_out",  mdi.Out,  32'd0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
            check($sformatf("vec%0d_busy_cycles", i), n, vecs[i].lat);
            check($sformatf("vec%0d_hi", i), mdi.HI, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), mdi.LO, vecs[i].lo);
            mdi.RdSel = 1'b1;
            #1;
            check($sformatf("vec%0d_out_hi", i), mdi.Out, vecs[i].hi);
            mdi.RdSel = 1'b0;
            #1;
            check($sformatf("vec%0d_out_lo", i), mdi.Out, vecs[i].lo);
        end

        // mthi / mtlo: single-edge writes, no busy
        @(negedge clk);
        mdi.MDOp = MDOP_MTHI;
        mdi.A    = 32'h1234_5678;
        @(posedge clk);
        #1;
        mdi.MDOp  = MDOP_NONE;
        mdi.RdSel = 1'b1;
        #1;
        check("mthi_busy", {31'd0, mdi.Busy}, 32'd0);
        check("mthi_out",  mdi.Out, 32'h1234_5678);
        @(negedge clk);
        mdi.MDOp = MDOP_MTLO;
        mdi.A    = 32'hCAFE_BABE;
        @(posedge clk);
        #1;
        mdi.MDOp  = MDOP_NONE;
        mdi.RdSel = 1'b0;
        #1;
        check("mtlo_busy", {31'd0, mdi.Busy}, 32'd0);
        check("mtlo_out",  mdi.Out, 32'hCAFE_BABE);
        check("mtlo_hi_kept", mdi.HI, 32'h1234_5678);

        // mult 2*3 with mtlo, operand changes and a div start injected while busy
        @(negedge clk);
        mdi.MDOp = MDOP_MULT;
        mdi.A    = 32'd2;
        mdi.B    = 32'd3;
        @(posedge clk);
        #1;
        n = 0;
        while (mdi.Busy && n < 100) begin
            case (n)
                0: begin mdi.MDOp = MDOP_MTLO; mdi.A = 32'hDEAD_BEEF; mdi.B = 32'd77; end
                1: begin mdi.MDOp = MDOP_DIV;  mdi.A = 32'd100;       mdi.B = 32'd3;  end
                default: mdi.MDOp = MDOP_NONE;
            endcase
            if (n == 0) begin
                @(negedge clk);
                check("busy_read_old_lo", mdi.Out, 32'hCAFE_BABE);
            end
            @(posedge clk);
            #1;
            n++;
        end
        check("busy_seq_cycles", n, 5);
        check("busy_seq_hi", mdi.HI, 32'd0);
        check("busy_seq_lo", mdi.LO, 32'd6);
        @(posedge clk);
        #1;
        check("ignored_start_busy", {31'd0, mdi.Busy}, 32'd0);

        // back-to-back: start in first idle cycle after a completion
        run_op(MDOP_MULTU, 32'd10, 32'd20, n);
        run_op(MDOP_DIVU, 32'd50, 32'd8, n);
        check("b2b_cycles", n, 10);
        check("b2b_hi", mdi.HI, 32'd2);
        check("b2b_lo", mdi.LO, 32'd6);

        // reset on the 3rd busy cycle of a mult aborts it
        @(negedge clk);
        mdi.MDOp = MDOP_MTHI;
        mdi.A    = 32'hAAAA_5555;
        @(negedge clk);
        mdi.MDOp = MDOP_MULT;
        mdi.A    = 32'h10;
        mdi.B    = 32'h10;
        @(posedge clk);
        #1;
        mdi.MDOp = MDOP_NONE;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("pre_reset_busy", {31'd0, mdi.Busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_busy", {31'd0, mdi.Busy}, 32'd0);
        check("abort_hi", mdi.HI, 32'd0);
        check("abort_lo", mdi.LO, 32'd0);
        repeat (8) @(posedge clk);
        #1;
        check("abort_no_late_hi", mdi.HI, 32'd0);
        check("abort_no_late_lo", mdi.LO, 32'd0);
        check("abort_idle", {31'd0, mdi.Busy}, 32'd0);

        // reset wins over mthi in the same cycle
        @(negedge clk);
        reset    = 1'b1;
        mdi.MDOp = MDOP_MTHI;
        mdi.A    = 32'h0000_0005;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        mdi.MDOp = MDOP_NONE;
        check("reset_wins_hi", mdi.HI, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
